// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit that sits beside the MIPS ALU.
// One multiplier bit or one quotient bit is processed per cycle; results
// come back in HI/LO form (Result1 = LO, Result2 = HI).
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             div_zero
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  // Magnitude of a possibly-signed operand; the most-negative value maps to
  // 2^(WIDTH-1), which still fits the unsigned WIDTH-bit result.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_div, sgn, x_neg, y_neg, q_neg;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum, mul_add;
  logic [WIDTH:0]     div_trial, div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   fin_lo, fin_hi;
  logic               fin_dz;

  // One iteration of the shared datapath plus sign fix-up of the final value.
  // The accumulator holds {HI, LO}: for multiply LO starts as |X| and is
  // shifted out as product bits arrive; for divide LO starts as |X| and is
  // replaced bit by bit with the quotient while HI carries the remainder.
  always_comb begin
    is_div = op_q[1];
    sgn    = op_q[0];
    x_neg  = sgn & x_q[WIDTH-1];
    y_neg  = sgn & y_q[WIDTH-1];
    q_neg  = x_neg ^ y_neg;
    b_mag  = mag(y_q, sgn);

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_mag};
    mul_add = acc_q[0] ? mul_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_sub   = div_trial - {1'b0, b_mag};
    div_ge    = ~div_sub[WIDTH];

    if (is_div) begin
      step = {(div_ge ? div_sub[WIDTH-1:0] : div_trial[WIDTH-1:0]),
              acc_q[WIDTH-2:0], div_ge};
    end else begin
      step = {mul_add, acc_q[WIDTH-1:1]};
    end

    prod = q_neg ? (~step + ONE_2W) : step;
    quot = q_neg ? (~step[WIDTH-1:0] + ONE_W) : step[WIDTH-1:0];
    rem  = x_neg ? (~step[2*WIDTH-1:WIDTH] + ONE_W) : step[2*WIDTH-1:WIDTH];

    if (!is_div) begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_dz = 1'b0;
    end else if (y_q == '0) begin
      fin_lo = '1;
      fin_hi = x_q;
      fin_dz = 1'b1;
    end else begin
      fin_lo = quot;
      fin_hi = rem;
      fin_dz = 1'b0;
    end
  end

  // Next-state logic: accept in IDLE/DONE, iterate in BUSY, publish on the last step.
  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case leaves a signal unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    dz_d    = dz_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
          op_d    = op;
          x_d     = X;
          y_d     = Y;
          acc_d   = {{WIDTH{1'b0}}, mag(X, op[0])};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          res1_d  = fin_lo;
          res2_d  = fin_hi;
          dz_d    = fin_dz;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and accumulator flops are reset too; they are plain registers, not a memory array, so nothing here ever powers up as X.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Result1  = res1_q;
  assign Result2  = res2_q;
  assign div_zero = dz_q;

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised iterative multiply/divide unit for the MIPS datapath, operating beside the combinational ALU. It executes MULT/MULTU/DIV/DIVU over a fixed number of cycles using a start/busy/done handshake. Results are returned in the ALU's HI/LO convention: Result1 = LO, Result2 = HI. The pipeline stalls on `busy` and captures the results on `done`.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  operation, sampled with start: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- X  in  WIDTH  multiplicand or dividend, sampled with start.
- Y  in  WIDTH  multiplier or divisor, sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- Result1  out  WIDTH  LO: low product half, or quotient.
- Result2  out  WIDTH  HI: high product half, or remainder.
- div_zero  out  1  last completed operation was a divide by Y = 0.

## Operation
- FSM states:
  - IDLE: if start = 1, latch op, X and Y; load the counter with WIDTH; go to BUSY.
  - BUSY: perform one iteration per cycle and decrement the counter; when the counter reaches 1 on an edge, go to DONE.
  - DONE: update the outputs. If start = 1, accept the new operation and go to BUSY (back-to-back issue). Otherwise go to IDLE.
- start in BUSY is ignored; it is neither queued nor restarts the operation.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes, the unsigned core runs, then the signs are applied.
  - Product sign = sign(X) xor sign(Y).
  - Quotient sign = sign(X) xor sign(Y). Remainder sign = sign(X).
  - The magnitude of the most-negative operand is represented as unsigned 2^(WIDTH-1).
- Multiply: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. {Result2, Result1} = full product.
- Divide: restoring, one quotient bit per cycle. Result1 = quotient, truncated toward zero. Result2 = remainder.
- DIV overflow (most-negative / −1): Result1 = most-negative value, Result2 = 0, no flag.
- Divide by zero: fixed latency is kept. Result1 = all ones, Result2 = X as sampled, div_zero = 1.
- div_zero is cleared to 0 at the completion of any other operation.
- Result1, Result2 and div_zero are registered. They hold the previous results through BUSY and change only on the edge that enters DONE.

## Timing
- Reset values: busy = 0, done = 0, Result1 = 0, Result2 = 0, div_zero = 0, FSM = IDLE, counter = 0.
- Latency: start sampled at edge E → busy = 1 after E through edge E+WIDTH. At edge E+WIDTH the FSM enters DONE: done = 1, busy = 0, results valid. Latency is WIDTH cycles, identical for all ops including divide-by-zero.
- done is high for exactly one cycle unless start is sampled in DONE. In that case busy rises at the next edge and done falls.
- Throughput: one operation per WIDTH cycles with back-to-back issue.
- X, Y and op may change freely after the sampling edge.
- rst_n low at any time, including mid-BUSY: immediately force every output and the FSM to reset values and discard the operation. The first start is accepted at the first rising edge after rst_n goes high.

## Test plan
- MULTU, X = 0x00001249, Y = 0xFFFFFF0F → after 32 cycles: done pulse, Result2 = 0x00001248, Result1 = 0xFFEEC947, div_zero = 0.
- MULT, same operands → Result2 = 0xFFFFFFFF, Result1 = 0xFFEEC947. DIVU, 100 / 7 → Result1 = 0x0000000E, Result2 = 0x00000002.
- DIV:
  - −7 / 2 → Result1 = 0xFFFFFFFD, Result2 = 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → Result1 = 0x80000000, Result2 = 0.
- DIVU, X = 0x1234, Y = 0 → 32-cycle latency, Result1 = 0xFFFFFFFF, Result2 = 0x00001234, div_zero = 1. Next MULTU 3 × 5 → Result1 = 15, Result2 = 0, div_zero = 0.
- Handshake:
  - start pulses held in BUSY are ignored; outputs keep the prior result until done.
  - start asserted in the DONE cycle → second result arrives exactly 32 cycles after the first done.
- rst_n pulsed low at cycle 10 of a DIVU → all outputs 0 immediately, no done pulse. A fresh DIVU 9 / 3 then gives Result1 = 3, Result2 = 0. Repeat the MULTU and DIVU checks with WIDTH = 8.
